requant_rr_scheduler: RTL

//  Time-shares one saturate/truncate requantizer (S(NB_XI,NBF_XI) -> S(NB_XO,NBF_XO)) between N_REQ streams.
//  Per-channel valid/ready inputs, round-robin arbitration, one registered output stage with channel tag and saturation flag.

---
 rtl/requant_rr_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/requant_rr_scheduler.sv
// Round-robin scheduler sharing one saturate/truncate requantizer S(NB_XI,NBF_XI) -> S(NB_XO,NBF_XO)
// between N_REQ valid/ready streams. Optional saturation event counter enabled by macro SAT_CNT_EN.
module requant_rr_scheduler #(
    parameter int N_REQ  = 4,
    parameter int NB_XI  = 20,
    parameter int NBF_XI = 12,
    parameter int NB_XO  = 8,
    parameter int NBF_XO = 6,
    parameter int NB_CNT = 16
) (
    input  logic                       clk,
    input  logic                       i_reset,
    input  logic [N_REQ-1:0]           i_valid,
    input  logic [N_REQ*NB_XI-1:0]     i_data,
    output logic [N_REQ-1:0]           o_ready,
    output logic                       o_valid,
    output logic [NB_XO-1:0]           o_data,
    output logic [$clog2(N_REQ)-1:0]   o_ch,
    output logic                       o_sat,
    input  logic                       i_ready
`ifdef SAT_CNT_EN
    ,
    output logic [NB_CNT-1:0]          o_sat_cnt
`endif
);

    localparam int CH_W  = $clog2(N_REQ);
    localparam int SHR   = (NBF_XI >= NBF_XO) ? (NBF_XI - NBF_XO) : 0;
    localparam int SHL   = (NBF_XO > NBF_XI) ? (NBF_XO - NBF_XI) : 0;
    localparam int NB_W  = NB_XI + NB_XO + NBF_XO + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Align the binary point (floor), then clamp to the output range; returns {sat, word}.
    // Range clamping is equivalent to checking the dropped integer bits against the sign bit.
    function automatic logic [NB_XO:0] requant(input logic [NB_XI-1:0] x);
        logic signed [NB_W-1:0] ext_v;
        logic signed [NB_W-1:0] al_v;
        logic signed [NB_W-1:0] max_v;
        logic signed [NB_W-1:0] min_v;
        logic        [NB_XO:0]  res_v;
        ext_v = {{(NB_W-NB_XI){x[NB_XI-1]}}, x};
        al_v  = (ext_v >>> SHR) <<< SHL;
        max_v = {{(NB_W-NB_XO+1){1'b0}}, {(NB_XO-1){1'b1}}};
        min_v = {{(NB_W-NB_XO+1){1'b1}}, {(NB_XO-1){1'b0}}};
        if (al_v > max_v) begin
            res_v = {1'b1, 1'b0, {(NB_XO-1){1'b1}}};
        end else if (al_v < min_v) begin
            res_v = {1'b1, 1'b1, {(NB_XO-1){1'b0}}};
        end else begin
            res_v = {1'b0, al_v[NB_XO-1:0]};
        end
        return res_v;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [CH_W-1:0]     last_grant_r;
    logic [CH_W-1:0]     grant_idx_s;
    logic                grant_found_s;
    logic                can_load_s;
    logic                load_s;
    logic [NB_XI-1:0]    sel_word_s;
    logic [NB_XO:0]      rq_s;

    // Round-robin search starting one past the last granted channel; first valid wins.
    always_comb begin
        logic [CH_W-1:0] cand_v;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_v        = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_v        = CH_W'((int'(last_grant_r) + i) % N_REQ);
            grant_idx_s   = (!grant_found_s && i_valid[cand_v]) ? cand_v : grant_idx_s;
            grant_found_s = grant_found_s | i_valid[cand_v];
        end
    end

    // Grant qualification: the output register must be free or draining this cycle.
    always_comb begin
        can_load_s = (state_r == EMPTY) || i_ready;
        load_s     = can_load_s && grant_found_s && !i_reset;
        if (load_s) begin
            o_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            o_ready = '0;
        end
    end

    assign sel_word_s = i_data[grant_idx_s*NB_XI +: NB_XI];
    assign rq_s       = requant(sel_word_s);

    // Output stage next-state: a held word is released only when downstream accepts it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY:   state_s = load_s ? FULL : EMPTY;
            FULL:    state_s = (i_ready && !load_s) ? EMPTY : FULL;
            default: state_s = EMPTY;
        endcase
    end

    // State, arbitration pointer and output word registers.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_r      <= EMPTY;
            last_grant_r <= CH_W'(N_REQ - 1);
            o_data       <= '0;
            o_ch         <= '0;
            o_sat        <= 1'b0;
        end else begin
            state_r <= state_s;
            if (load_s) begin
                last_grant_r <= grant_idx_s;
                o_data       <= rq_s[NB_XO-1:0];
                o_sat        <= rq_s[NB_XO];
                o_ch         <= grant_idx_s;
            end else begin
                last_grant_r <= last_grant_r;
                o_data       <= o_data;
                o_sat        <= o_sat;
                o_ch         <= o_ch;
            end
        end
    end

    assign o_valid = (state_r == FULL);

`ifdef SAT_CNT_EN
    logic [NB_CNT-1:0] sat_cnt_r;

    // Count saturated words as they leave; stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sat_cnt_r <= '0;
        end else if (o_valid && i_ready && o_sat && (sat_cnt_r != {NB_CNT{1'b1}})) begin
            sat_cnt_r <= sat_cnt_r + {{(NB_CNT-1){1'b0}}, 1'b1};
        end else begin
            sat_cnt_r <= sat_cnt_r;
        end
    end

    assign o_sat_cnt = sat_cnt_r;
`endif

endmodule
